shift_sequencer: RTL and testbench

- Multi-cycle controller for the core's 1-bit-per-cycle shift register datapath.
- Accepts an ARM shift request (LSL/LSR/ASR/ROR, data operand, amount) and steps the register one bit per clock. It tracks the remaining count and ARM shifter carry-out, and reports completion with a one-cycle done pulse.
- Sits between the decode/execute control and the ALU operand-2 path; it serves one requester at a time under a start/busy/done handshake.

---
 rtl/shift_sequencer.sv | 86 ++++++++
 tb/tb_shift_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// One-bit-per-clock ARM barrel-shift sequencer (LSL/LSR/ASR/ROR) with carry tracking.
// The shift is accepted from IDLE, run in SHIFT and reported by a one-cycle pulse in DONE.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_e           state_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [AMT_W-1:0] count_q;
  logic [1:0]       op_q;

  // Single-bit step of the currently latched operation.
  always_comb begin
    result_d = {result_q[0], result_q[WIDTH-1:1]};
    carry_d  = result_q[0];
    case (op_q)
      OP_LSL: begin
        result_d = {result_q[WIDTH-2:0], 1'b0};
        carry_d  = result_q[WIDTH-1];
      end
      OP_LSR: result_d = {1'b0, result_q[WIDTH-1:1]};
      OP_ASR: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      op_q     <= OP_LSL;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            result_q <= data_in;
            op_q     <= op;
            count_q  <= amount;
            carry_q  <= carry_in;
            state_q  <= (amount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          count_q  <= count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table for single operations plus
// hand-written sequences for reset, busy protection and mid-operation reset.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  amount = '0;
  logic [31:0] data_in = '0;
  logic        carry_in = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] result;

  int total = 0;
  int passed = 0;

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount),
    .data_in(data_in), .carry_in(carry_in), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic        cin;
    logic [31:0] exp_result;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Issue one request, wait (bounded) for done and check outcome and hold.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    op = v.op; amount = v.amt; data_in = v.data; carry_in = v.cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_in = 32'hDEAD_BEEF; amount = 5'd17; op = ~v.op; carry_in = ~v.cin;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({t, " latency"}, 32'(cyc), 32'(v.amt));
    check({t, " done"}, 32'(done), 32'd1);
    check({t, " busy"}, 32'(busy), 32'd1);
    check({t, " result"}, result, v.exp_result);
    check({t, " carry"}, 32'(carry_out), 32'(v.exp_carry));
    @(posedge clk); #1;
    check({t, " done_pulse_end"}, 32'(done), 32'd0);
    check({t, " idle_busy"}, 32'(busy), 32'd0);
    check({t, " result_hold"}, result, v.exp_result);
    check({t, " carry_hold"}, 32'(carry_out), 32'(v.exp_carry));
    $display("vec%0d op=%0d amt=%0d data=%h -> result=%h carry=%0d latency=%0d",
             idx, v.op, v.amt, v.data, result, carry_out, cyc);
  endtask

  initial begin
    int pulses;
    int done_cyc;

    vecs[0] = '{2'b00, 5'd1,  32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1};
    vecs[1] = '{2'b01, 5'd4,  32'h0000_00F0, 1'b0, 32'h0000_000F, 1'b0};
    vecs[2] = '{2'b10, 5'd31, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{2'b11, 5'd1,  32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1};
    vecs[4] = '{2'b11, 5'd31, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0};
    vecs[5] = '{2'b00, 5'd0,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
    vecs[6] = '{2'b00, 5'd31, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0};
    vecs[7] = '{2'b01, 5'd31, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[8] = '{2'b10, 5'd4,  32'h7FFF_FFFF, 1'b0, 32'h07FF_FFFF, 1'b1};
    vecs[9] = '{2'b11, 5'd8,  32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0};

    // Reset state
    @(negedge clk); rst = 1'b1; #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset carry", 32'(carry_out), 32'd0);
    @(negedge clk); rst = 1'b0;
    $display("reset: busy=%0d done=%0d result=%h carry=%0d", busy, done, result, carry_out);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Busy protection: LSL by 8 on 1, stray starts at shift edge 3 and during DONE
    @(negedge clk);
    op = 2'b00; amount = 5'd8; data_in = 32'h0000_0001; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; done_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 3) || done;
      data_in = 32'hFFFF_FFFF; op = 2'b01; amount = 5'd1;
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        done_cyc = c;
      end
    end
    start = 1'b0;
    check("busy_prot pulses", 32'(pulses), 32'd1);
    check("busy_prot latency", 32'(done_cyc), 32'd8);
    check("busy_prot result", result, 32'h0000_0100);
    check("busy_prot carry", 32'(carry_out), 32'd0);
    check("busy_prot idle", 32'(busy), 32'd0);
    $display("busy_prot: result=%h carry=%0d pulses=%0d done_at=%0d", result, carry_out, pulses, done_cyc);

    // Reset after 5 shifts of an LSR by 20
    @(negedge clk);
    op = 2'b01; amount = 5'd20; data_in = 32'hFFFF_F000; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst carry", 32'(carry_out), 32'd0);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("midrst no_done", 32'(pulses), 32'd0);
    $display("midrst: result=%h carry=%0d busy_cycles_after=%0d", result, carry_out, pulses);
    run_vec(10, '{2'b01, 5'd1, 32'h0000_0002, 1'b1, 32'h0000_0001, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
